// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM-side signal bundle for mem_port_arbiter
// slave is the arbiter's view; master is the requesters' and RAM's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_dm_req;
  logic              i_dm_we;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [DATA_W-1:0] i_dm_wdata;
  logic              o_dm_gnt;
  logic              o_dm_rvalid;
  logic [DATA_W-1:0] o_dm_rdata;

  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_data_in;
  logic [DATA_W-1:0] i_ram_data_out;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_ram_we, o_ram_addr, o_ram_data_in,
    input  i_ram_data_out
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_ram_we, o_ram_addr, o_ram_data_in,
    output i_ram_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port registered-read RAM
// Data wins ties until MAX_DSTREAK consecutive wins starve a waiting fetch.
module mem_port_arbiter #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 10,
  parameter int MAX_DSTREAK = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

  logic [3:0]        streak_q, streak_d;
  logic              if_pend_q, if_pend_d;
  logic              dm_pend_q, dm_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_gnt, dm_gnt;

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (bus.i_dm_req && (!bus.i_if_req || (streak_q < MAX_S))) begin
        dm_gnt = 1'b1;
      end else if (bus.i_if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Address/data hold their last driven value on idle cycles so the RAM inputs stay quiet.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (dm_gnt) begin
      addr_d  = bus.i_dm_addr;
      wdata_d = bus.i_dm_wdata;
    end else if (if_gnt) begin
      addr_d  = bus.i_if_addr;
      wdata_d = bus.i_dm_wdata;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !bus.i_if_req) begin
      streak_d = 4'd0;
    end else if (dm_gnt && (streak_q < MAX_S)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    if_pend_d = if_gnt;
    dm_pend_d = dm_gnt & ~bus.i_dm_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q  <= 4'd0;
      if_pend_q <= 1'b0;
      dm_pend_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      streak_q  <= streak_d;
      if_pend_q <= if_pend_d;
      dm_pend_q <= dm_pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.o_if_gnt      = if_gnt;
  assign bus.o_dm_gnt      = dm_gnt;
  assign bus.o_ram_we      = bus.i_dm_we & dm_gnt;
  assign bus.o_ram_addr    = addr_d;
  assign bus.o_ram_data_in = wdata_d;

  // Tags are masked by rst so a read issued just before reset never returns.
  assign bus.o_if_rvalid   = if_pend_q & ~rst;
  assign bus.o_dm_rvalid   = dm_pend_q & ~rst;
  assign bus.o_if_rdata    = bus.i_ram_data_out;
  assign bus.o_dm_rdata    = bus.i_ram_data_out;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Includes a 64x10 registered-read RAM model driven by the arbiter.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(6), .DATA_W(10)) bus ();

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(10), .MAX_DSTREAK(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit [9:0] mem [64];

  always @(posedge clk) begin
    if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_data_in;
    bus.i_ram_data_out <= mem[bus.o_ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [5:0] ia, input logic dr,
                       input logic dw, input logic [5:0] da, input logic [9:0] dd);
    bus.i_if_req   = ir;
    bus.i_if_addr  = ia;
    bus.i_dm_req   = dr;
    bus.i_dm_we    = dw;
    bus.i_dm_addr  = da;
    bus.i_dm_wdata = dd;
    #2;
  endtask

  logic [5:0] pre_addr [4];
  logic [9:0] pre_data [4];
  logic [7:0] dpat;
  logic [6:0] creq;
  logic [6:0] cdm;
  logic       prev_f;
  logic       prev_d;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b1, 6'd4, 1'b1, 1'b0, 6'd7, 10'h000);
    tick();
    tick();
    #2;
    check("rst_if_gnt", bus.o_if_gnt, 0);
    check("rst_dm_gnt", bus.o_dm_gnt, 0);
    check("rst_ram_we", bus.o_ram_we, 0);
    check("rst_if_rvalid", bus.o_if_rvalid, 0);
    check("rst_dm_rvalid", bus.o_dm_rvalid, 0);
    check("rst_ram_addr", bus.o_ram_addr, 0);
    check("rst_ram_data_in", bus.o_ram_data_in, 0);
    rst = 1'b0;
    #1;
    check("post_rst_dm_gnt", bus.o_dm_gnt, 1);
    check("post_rst_if_gnt", bus.o_if_gnt, 0);
    check("post_rst_ram_addr", bus.o_ram_addr, 7);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    check("post_rst_dm_rvalid", bus.o_dm_rvalid, 1);
    check("post_rst_dm_rdata", bus.o_dm_rdata, 0);
    check("post_rst_if_rvalid", bus.o_if_rvalid, 0);
    tick();

    pre_addr[0] = 6'd1; pre_data[0] = 10'h011;
    pre_addr[1] = 6'd2; pre_data[1] = 10'h022;
    pre_addr[2] = 6'd3; pre_data[2] = 10'h033;
    pre_addr[3] = 6'd5; pre_data[3] = 10'h2A5;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 6'd0, 1'b1, 1'b1, pre_addr[i], pre_data[i]);
      check("preload_ram_we", bus.o_ram_we, 1);
      check("preload_ram_addr", bus.o_ram_addr, {26'd0, pre_addr[i]});
      tick();
    end

    drive(1'b1, 6'd5, 1'b0, 1'b0, 6'd0, 10'h000);
    check("write_no_rvalid", bus.o_dm_rvalid, 0);
    check("fetch_if_gnt", bus.o_if_gnt, 1);
    check("fetch_dm_gnt", bus.o_dm_gnt, 0);
    check("fetch_ram_addr", bus.o_ram_addr, 5);
    check("fetch_ram_we", bus.o_ram_we, 0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    check("fetch_if_rvalid", bus.o_if_rvalid, 1);
    check("fetch_if_rdata", bus.o_if_rdata, 10'h2A5);
    check("fetch_dm_rvalid", bus.o_dm_rvalid, 0);
    check("idle_addr_hold", bus.o_ram_addr, 5);
    check("idle_ram_we", bus.o_ram_we, 0);
    tick();

    drive(1'b0, 6'd0, 1'b1, 1'b1, 6'd9, 10'h155);
    check("wr_ram_we", bus.o_ram_we, 1);
    check("wr_ram_addr", bus.o_ram_addr, 9);
    check("wr_ram_data_in", bus.o_ram_data_in, 10'h155);
    tick();
    drive(1'b0, 6'd0, 1'b1, 1'b0, 6'd9, 10'h155);
    check("rd_dm_gnt", bus.o_dm_gnt, 1);
    check("rd_ram_we", bus.o_ram_we, 0);
    check("wr_no_dm_rvalid", bus.o_dm_rvalid, 0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    check("rd_dm_rvalid", bus.o_dm_rvalid, 1);
    check("rd_dm_rdata", bus.o_dm_rdata, 10'h155);
    tick();

    drive(1'b1, 6'd1, 1'b0, 1'b0, 6'd0, 10'h000);
    check("b2b_gnt1", bus.o_if_gnt, 1);
    tick();
    drive(1'b0, 6'd0, 1'b1, 1'b0, 6'd2, 10'h000);
    check("b2b_gnt2", bus.o_dm_gnt, 1);
    check("b2b_if_rvalid1", bus.o_if_rvalid, 1);
    check("b2b_if_rdata1", bus.o_if_rdata, 10'h011);
    check("b2b_dm_rvalid1", bus.o_dm_rvalid, 0);
    tick();
    drive(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 10'h000);
    check("b2b_gnt3", bus.o_if_gnt, 1);
    check("b2b_dm_rvalid2", bus.o_dm_rvalid, 1);
    check("b2b_dm_rdata2", bus.o_dm_rdata, 10'h022);
    check("b2b_if_rvalid2", bus.o_if_rvalid, 0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    check("b2b_if_rvalid3", bus.o_if_rvalid, 1);
    check("b2b_if_rdata3", bus.o_if_rdata, 10'h033);
    check("b2b_dm_rvalid3", bus.o_dm_rvalid, 0);
    tick();

    dpat   = 8'b0111_0111;
    prev_f = 1'b0;
    prev_d = 1'b0;
    drive(1'b1, 6'd1, 1'b1, 1'b0, 6'd2, 10'h000);
    for (int i = 0; i < 8; i++) begin
      check("starve_dm_gnt", bus.o_dm_gnt, {31'd0, dpat[i]});
      check("starve_if_gnt", bus.o_if_gnt, {31'd0, ~dpat[i]});
      check("starve_if_rvalid", bus.o_if_rvalid, {31'd0, prev_f});
      check("starve_dm_rvalid", bus.o_dm_rvalid, {31'd0, prev_d});
      if (prev_f) check("starve_if_rdata", bus.o_if_rdata, 10'h011);
      if (prev_d) check("starve_dm_rdata", bus.o_dm_rdata, 10'h022);
      prev_f = ~dpat[i];
      prev_d = dpat[i];
      tick();
      #2;
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    check("starve_last_if_rvalid", bus.o_if_rvalid, 1);
    check("starve_last_if_rdata", bus.o_if_rdata, 10'h011);
    tick();

    creq = 7'b111_1011;
    cdm  = 7'b011_1111;
    for (int i = 0; i < 7; i++) begin
      drive(creq[i], 6'd1, 1'b1, 1'b0, 6'd2, 10'h000);
      check("clr_dm_gnt", bus.o_dm_gnt, {31'd0, cdm[i]});
      check("clr_if_gnt", bus.o_if_gnt, {31'd0, creq[i] & ~cdm[i]});
      tick();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    tick();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd1, 1'b1, 1'b0, 6'd3, 10'h000);
      check("rst1_pre_dm_gnt", bus.o_dm_gnt, 1);
      tick();
    end
    rst = 1'b1;
    #2;
    check("rst1_if_gnt", bus.o_if_gnt, 0);
    check("rst1_dm_gnt", bus.o_dm_gnt, 0);
    check("rst1_dm_rvalid", bus.o_dm_rvalid, 0);
    tick();
    rst = 1'b0;
    #2;
    check("rst1_after_dm_gnt", bus.o_dm_gnt, 1);
    check("rst1_after_if_gnt", bus.o_if_gnt, 0);
    tick();

    drive(1'b1, 6'd5, 1'b0, 1'b0, 6'd0, 10'h000);
    check("rst2_if_gnt", bus.o_if_gnt, 1);
    tick();
    rst = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 10'h000);
    check("rst2_if_rvalid", bus.o_if_rvalid, 0);
    tick();
    rst = 1'b0;
    #2;
    check("rst2_after_if_rvalid", bus.o_if_rvalid, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the 64x10 block RAM and is its only driver.
- Merges two requesters onto the single RAM port: the CPU instruction-fetch stage and the load/store (data) stage.
- Handles the RAM's one-cycle registered read latency and routes returned data back to the requester that issued the read.
- Data has priority; a streak counter guarantees fetch forward progress.

Parameters:
ADDR_W, 6, RAM address width; must match the RAM SIZE parameter
DATA_W, 10, RAM word width
MAX_DSTREAK, 3, max consecutive data grants while fetch is waiting (1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
i_if_req  input  1  fetch read request (held until granted)
i_if_addr  input  ADDR_W  fetch address
o_if_gnt  output  1  fetch request accepted this cycle
o_if_rvalid  output  1  fetch read data valid
o_if_rdata  output  DATA_W  fetch read data
i_dm_req  input  1  data request (held until granted)
i_dm_we  input  1  1=write, 0=read
i_dm_addr  input  ADDR_W  data address
i_dm_wdata  input  DATA_W  write data
o_dm_gnt  output  1  data request accepted this cycle
o_dm_rvalid  output  1  data read data valid (reads only)
o_dm_rdata  output  DATA_W  data read data
o_ram_we  output  1  to RAM i_we
o_ram_addr  output  ADDR_W  to RAM i_addr
o_ram_data_in  output  DATA_W  to RAM i_ram_data_in
i_ram_data_out  input  DATA_W  from RAM o_ram_data_out

Behaviour:
- Grant is combinational within cycle N from the requests and the registered streak counter. At most one of o_if_gnt/o_dm_gnt is high per cycle.
- Arbitration:
  - Only one request high: that request wins.
  - Both high and streak < MAX_DSTREAK: data wins.
  - Both high and streak == MAX_DSTREAK: fetch wins.
- RAM drive in the grant cycle:
  - o_ram_addr = winner's address.
  - o_ram_we = i_dm_we & o_dm_gnt.
  - o_ram_data_in = i_dm_wdata.
  - With no grant: o_ram_we=0, o_ram_addr and o_ram_data_in hold their previous values (registered-hold mux), 0 after reset.
- Streak counter (4 bits), updated at posedge:
  - Increments when o_dm_gnt & i_if_req.
  - Clears when o_if_gnt or !i_if_req.
  - Otherwise holds.
  - Never exceeds MAX_DSTREAK.
- Read tag register (2 bits: {if_pending, dm_pending}):
  - Set at posedge from the cycle-N grant: if_pending = o_if_gnt; dm_pending = o_dm_gnt & !i_dm_we.
  - Cycle N+1: o_if_rvalid = if_pending, o_dm_rvalid = dm_pending.
  - o_if_rdata and o_dm_rdata both equal i_ram_data_out, valid only while the matching rvalid is high.
  - Read latency: exactly 1 cycle from grant to rvalid.
  - Back-to-back grants give one rvalid per cycle.
- Writes produce no rvalid. A write granted in cycle N is visible to any read granted in cycle N+1 or later.
- A read and a write to the same address cannot occur in the same cycle (single port), so there is no same-cycle hazard.
- Reset (rst high at posedge):
  - Streak, tags, and held address/data registers clear to 0.
  - While rst is high: o_if_gnt=0, o_dm_gnt=0, o_ram_we=0, o_if_rvalid=0, o_dm_rvalid=0.
  - A read granted the cycle before rst must not produce rvalid.
  - Requests held through rst are arbitrated normally in the first cycle after rst drops.
- No FIFOs; requesters must hold req/addr/data stable until they see gnt.

Test Plan:
- Fetch-only read: preload RAM[5]=10'h2A5, i_if_req=1 with addr 5 for one cycle -> o_if_gnt=1 that cycle, o_if_rvalid=1 and o_if_rdata=10'h2A5 next cycle, o_dm_rvalid=0.
- Write then read: data write addr 9 data 10'h155, next cycle data read addr 9 -> o_ram_we=1 only in the first cycle, o_dm_rvalid=1 with 10'h155 one cycle after the read grant, no rvalid for the write.
- Starvation: both requesting continuously (data reads, MAX_DSTREAK=3) -> grant pattern D,D,D,F,D,D,D,F; each fetch rvalid one cycle after its grant.
- Back-to-back alternating: fetch addr 1, data read addr 2, fetch addr 3 on consecutive cycles -> rvalids on consecutive cycles with RAM[1], RAM[2], RAM[3] routed to the correct port.
- Reset mid-operation: fetch read granted at cycle N, rst=1 at cycle N+1 -> o_if_rvalid=0 at N+1; after rst drops, streak=0 and the first simultaneous request grants data.
- Streak clear: fetch drops its request after two data-priority cycles, then reasserts -> data wins three more times before fetch is granted.
